// File: rtl/key_event.sv
// key_event: turns debounced press/release pulses into click events.
// Detects single click, double click, long press and (optionally) the
// long-press auto-repeat.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   key_p_flag   1-cycle debounced press pulse
//   key_r_flag   1-cycle debounced release pulse
//   single_click 1-cycle pulse, one short press completed
//   double_click 1-cycle pulse, two short presses within GAP_CNT
//   long_press   1-cycle pulse, key held LONG_CNT cycles
//   long_rep     1-cycle pulse every REP_CNT cycles while held long
//   key_busy     high while a gesture is in progress
//
// Build option: define KEY_REPEAT_EN to compile in long_rep.
// Without it long_rep is tied low and REP_CNT is unused.

module key_event #(
  parameter logic [25:0] LONG_CNT = 26'd50_000_000,
  parameter logic [25:0] GAP_CNT  = 26'd15_000_000,
  parameter logic [25:0] REP_CNT  = 26'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_p_flag,
  input  logic key_r_flag,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic long_rep,
  output logic key_busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic [25:0] LONG_LAST = LONG_CNT - 26'd1;
  localparam logic [25:0] GAP_LAST  = GAP_CNT - 26'd1;

  state_t      state;
  logic [25:0] cnt;

`ifdef KEY_REPEAT_EN
  localparam logic [25:0] REP_LAST = REP_CNT - 26'd1;
`else
  logic unused_rep;
  assign unused_rep = ^REP_CNT;
  assign long_rep   = 1'b0;
`endif

  // Every transition clears cnt; every pulse is a registered
  // one-cycle strobe that drops back to 0 the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      key_busy     <= 1'b0;
`ifdef KEY_REPEAT_EN
      long_rep     <= 1'b0;
`endif
    end else begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
`ifdef KEY_REPEAT_EN
      long_rep     <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (key_p_flag) begin
            state    <= PRESS1;
            key_busy <= 1'b1;
          end
        end

        // Release wins over a coincident long timeout.
        PRESS1: begin
          if (key_r_flag) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end

        // A second press wins over a coincident gap timeout.
        WAIT2: begin
          if (key_p_flag) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b1;
            key_busy     <= 1'b0;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end

        PRESS2: begin
          cnt <= '0;
          if (key_r_flag) begin
            state        <= IDLE;
            double_click <= 1'b1;
            key_busy     <= 1'b0;
          end
        end

        // Release ends the hold silently and beats a due repeat.
        LONG: begin
          if (key_r_flag) begin
            state    <= IDLE;
            cnt      <= '0;
            key_busy <= 1'b0;
          end else begin
`ifdef KEY_REPEAT_EN
            if (cnt == REP_LAST) begin
              cnt      <= '0;
              long_rep <= 1'b1;
            end else begin
              cnt <= cnt + 26'd1;
            end
`else
            cnt <= '0;
`endif
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: random and directed stimulus for key_event,
// checked every cycle against a timestamp-based gesture model.

module tb_key_event;

  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int REP  = 5;
`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_p_flag = 1'b0;
  logic key_r_flag = 1'b0;
  logic single_click;
  logic double_click;
  logic long_press;
  logic long_rep;
  logic key_busy;

  int checks = 0;
  int errors = 0;

  // model: cycle of each accepted gesture edge, -1 when not set
  int n = 0;
  int t_p1 = -1;
  int t_r1 = -1;
  int t_p2 = -1;
  int t_lg = -1;

  int n_s, n_d, n_l, n_r;

  always #5 clk = ~clk;

  key_event #(
    .LONG_CNT(26'd20),
    .GAP_CNT (26'd10),
    .REP_CNT (26'd5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_p_flag  (key_p_flag),
    .key_r_flag  (key_r_flag),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .long_rep    (long_rep),
    .key_busy    (key_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got %0h exp %0h at cycle %0d",
                 tag, got, exp, n);
    end
  endtask

  task automatic clr_model();
    t_p1 = -1;
    t_r1 = -1;
    t_p2 = -1;
    t_lg = -1;
  endtask

  // Expected outputs for the cycle after flags sampled in cycle n:
  // {single, double, long, rep, busy}
  task automatic model(input bit p, input bit r, input bit rs,
                       output logic [4:0] e);
    bit s, d, l, rp;
    s = 0; d = 0; l = 0; rp = 0;
    if (rs) begin
      clr_model();
    end else if (t_p2 >= 0) begin
      if (r) begin
        d = 1;
        clr_model();
      end
    end else if (t_lg >= 0) begin
      if (r)
        clr_model();
      else if (REP_ON && n > t_lg && ((n - t_lg) % REP) == 0)
        rp = 1;
    end else if (t_r1 >= 0) begin
      if (p)
        t_p2 = n;
      else if (n - t_r1 == GAP) begin
        s = 1;
        clr_model();
      end
    end else if (t_p1 >= 0) begin
      if (r)
        t_r1 = n;
      else if (n - t_p1 == LONG) begin
        l = 1;
        t_lg = n;
      end
    end else if (p) begin
      t_p1 = n;
    end
    e = {s, d, l, rp, (t_p1 >= 0)};
  endtask

  task automatic step(input bit p, input bit r, input bit rs);
    logic [4:0] e;
    logic [4:0] g;
    key_p_flag = p;
    key_r_flag = r;
    rst = rs;
    model(p, r, rs, e);
    @(posedge clk);
    #1;
    g = {single_click, double_click, long_press, long_rep, key_busy};
    chk("outs", {27'd0, g}, {27'd0, e});
    chk("onehot", {31'd0, $onehot0(g[4:1])}, 32'd1);
    n_s += int'(g[4]);
    n_d += int'(g[3]);
    n_l += int'(g[2]);
    n_r += int'(g[1]);
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0);
  endtask

  task automatic clr_tally();
    n_s = 0; n_d = 0; n_l = 0; n_r = 0;
  endtask

  initial begin
    clr_tally();
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_busy", {31'd0, key_busy}, 32'd0);
    idle(3);

    // single click
    clr_tally();
    step(1, 0, 0); idle(4); step(0, 1, 0); idle(15);
    chk("sgl_s", n_s, 1);
    chk("sgl_dlr", n_d + n_l + n_r, 0);

    // double click
    clr_tally();
    step(1, 0, 0); idle(4); step(0, 1, 0); idle(3);
    step(1, 0, 0); idle(4); step(0, 1, 0); idle(15);
    chk("dbl_d", n_d, 1);
    chk("dbl_s", n_s, 0);

    // long press with hold to cycle 40
    clr_tally();
    step(1, 0, 0); idle(39); step(0, 1, 0); idle(3);
    chk("lng_l", n_l, 1);
    chk("lng_r", n_r, REP_ON ? 3 : 0);
    chk("lng_busy", {31'd0, key_busy}, 32'd0);

    // release on the long boundary: release wins
    clr_tally();
    step(1, 0, 0); idle(19); step(0, 1, 0); idle(12);
    chk("bnd_l", n_l, 0);
    chk("bnd_s", n_s, 1);

    // press on the gap boundary: press wins
    clr_tally();
    step(1, 0, 0); idle(4); step(0, 1, 0); idle(9);
    step(1, 0, 0); idle(3); step(0, 1, 0); idle(12);
    chk("gap_s", n_s, 0);
    chk("gap_d", n_d, 1);

    // reset in PRESS1, WAIT2 and LONG
    step(1, 0, 0); idle(3); step(0, 0, 1);
    clr_tally(); idle(30);
    chk("rst_p1", n_s + n_d + n_l + n_r, 0);
    step(1, 0, 0); idle(4); step(0, 1, 0); idle(2); step(0, 0, 1);
    clr_tally(); idle(20);
    chk("rst_w2", n_s + n_d + n_l + n_r, 0);
    step(1, 0, 0); idle(25); step(0, 0, 1);
    clr_tally(); idle(20);
    chk("rst_lg", n_s + n_d + n_l + n_r, 0);

    // stray release in IDLE
    clr_tally();
    step(0, 1, 0); idle(15);
    chk("stray", n_s + n_d + n_l + n_r, 0);
    chk("stray_busy", {31'd0, key_busy}, 32'd0);

    // random flags, occasional reset
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_CNT, default 26'd50_000_000, sets the hold time that counts as a long press (1 s at 50 MHz).
REQ-002 Parameter GAP_CNT, default 26'd15_000_000, sets the release window in which a second press counts as a double click (300 ms).
REQ-003 Parameter REP_CNT, default 26'd5_000_000, sets the auto-repeat period while a long press is held (100 ms); it is used only under KEY_REPEAT_EN.
REQ-004 All parameters SHALL be ≥2 and <2^26; the block is not required to behave correctly outside that range.
REQ-005 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 key_p_flag  input  1  one-cycle pulse from the debouncer: key pressed (debounced).
REQ-008 key_r_flag  input  1  one-cycle pulse from the debouncer: key released (debounced).
REQ-009 single_click  output  1  one-cycle pulse: single short press completed.
REQ-010 double_click  output  1  one-cycle pulse: two short presses within GAP_CNT.
REQ-011 long_press  output  1  one-cycle pulse: key held for LONG_CNT cycles.
REQ-012 long_rep  output  1  one-cycle pulse every REP_CNT cycles while long press is held; tied 0 without KEY_REPEAT_EN.
REQ-013 key_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM states SHALL be: IDLE, PRESS1, WAIT2, PRESS2, LONG; a single 26-bit counter cnt SHALL be cleared on every state change.
REQ-015 IDLE: key_p_flag -> PRESS1; key_r_flag is ignored.
REQ-016 PRESS1: cnt increments each cycle; key_r_flag while cnt<LONG_CNT-1 -> WAIT2; if cnt==LONG_CNT-1 with no key_r_flag -> LONG and pulse long_press.
REQ-017 PRESS1: if key_r_flag and cnt==LONG_CNT-1 in the same cycle, release wins -> WAIT2, no long_press.
REQ-018 WAIT2: cnt increments; key_p_flag -> PRESS2; if cnt==GAP_CNT-1 without key_p_flag -> IDLE and pulse single_click; simultaneous key_p_flag and timeout -> PRESS2, no single_click.
REQ-019 PRESS2: key_r_flag -> IDLE and pulse double_click; no timeout in PRESS2; the counter is held at 0.
REQ-020 LONG: key_r_flag -> IDLE with no pulse; under KEY_REPEAT_EN cnt increments and on cnt==REP_CNT-1 pulses long_rep and wraps cnt to 0.
REQ-021 key_p_flag in PRESS1, PRESS2 or LONG, and key_r_flag in WAIT2, SHALL be ignored.
REQ-022 All outputs SHALL be registered and pulse in the cycle after the qualifying flag/timeout edge, with latency 1 clk; at most one of single_click/double_click/long_press/long_rep is high in any cycle.
REQ-023 key_busy SHALL be registered from the next state, i.e. high in the cycle after key_p_flag in IDLE.

Reset
REQ-024 While rst=1 at a clk edge: state<=IDLE, cnt<=0, all pulse outputs<=0, key_busy<=0.
REQ-025 Reset asserted mid-sequence (any state) SHALL abort it with no pending pulse emitted afterward; the first flag accepted after reset is a key_p_flag in IDLE.

Configuration
REQ-026 Macro KEY_REPEAT_EN: when defined, LONG-state auto-repeat per REQ-020 is compiled in.
REQ-027 Without KEY_REPEAT_EN: long_rep is constant 0, cnt is held at 0 in LONG, and no repeat logic is synthesized.

Verification (LONG_CNT=20, GAP_CNT=10, REP_CNT=5)
REQ-028 p_flag@t0, r_flag@t0+5, no press for 10 cycles -> single_click one cycle high at t0+5+10+1; nothing else.
REQ-029 p@0, r@5, p@9, r@14 -> double_click single pulse at 15; no single_click ever.
REQ-030 p@0, hold, r@40 -> long_press at 21; with KEY_REPEAT_EN long_rep at 26,31,36 (and 41 is absent); without it long_rep stays 0; key_busy falls at 41.
REQ-031 p@0, r_flag exactly at the LONG_CNT-1 cycle -> no long_press; single_click later per timeout; p_flag coincident with WAIT2 timeout -> PRESS2, no single_click.
REQ-032 rst=1 for one cycle in PRESS1, WAIT2 and LONG respectively -> all outputs 0 next cycle, no event pulse afterward; a stray r_flag in IDLE -> no response.
